// File: rtl/hash_job_arbiter.sv
// Round-robin arbiter that lends one hash engine to NumReq requesters, one job at a time,
// with a WAIT_DONE watchdog and an engine-wiping abort path.
module hash_job_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumReq-1:0]      req_i,
    input  logic [NumReq-1:0]      start_i,
    input  logic [NumReq-1:0]      process_i,
    input  logic [NumReq-1:0]      wvalid_i,
    input  logic [NumReq*32-1:0]   wdata_i,
    input  logic [NumReq*4-1:0]    wmask_i,
    output logic [NumReq-1:0]      gnt_o,
    output logic [NumReq-1:0]      wready_o,
    output logic [NumReq-1:0]      done_o,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] owner_o,
    output logic                   eng_sha_en_o,
    output logic                   eng_hash_start_o,
    output logic                   eng_hash_process_o,
    output logic                   eng_msg_req_o,
    output logic                   eng_msg_we_o,
    output logic [31:0]            eng_msg_wdata_o,
    output logic [3:0]             eng_msg_mask_o,
    input  logic                   eng_msg_gnt_i,
    input  logic                   eng_hash_done_i,
    output logic                   timeout_o,
    output logic                   violation_o
);
    localparam int unsigned OW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ACTIVE    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_ABORT     = 2'd3
    } state_t;

    state_t              r_state;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_last_owner;
    logic                r_pend_proc;
    logic [WdW-1:0]      r_wd;
    logic                r_abort_cnt;
    logic [NumReq-1:0]   r_gnt;
    logic [NumReq-1:0]   r_done;
    logic                r_timeout;
    logic                r_violation;

    logic                w_start;
    logic                w_process;
    logic                w_wvalid;
    logic                w_req;
    logic [31:0]         w_wdata;
    logic [3:0]          w_mask;
    logic [OW-1:0]       w_pick;
    logic [NumReq-1:0]   w_pick_oh;
    int                  w_best;
    int                  w_dist;
    logic                w_act;
    logic                w_np;

    // Owner's view of the requester buses.
    always_comb begin
        w_start   = 1'b0;
        w_process = 1'b0;
        w_wvalid  = 1'b0;
        w_req     = 1'b0;
        w_wdata   = '0;
        w_mask    = '0;
        for (int j = 0; j < int'(NumReq); j++) begin
            if (r_owner == OW'(j)) begin
                w_start   = start_i[j];
                w_process = process_i[j];
                w_wvalid  = wvalid_i[j];
                w_req     = req_i[j];
                w_wdata   = wdata_i[j*32 +: 32];
                w_mask    = wmask_i[j*4 +: 4];
            end
        end
    end

    // Round-robin pick: smallest distance past last_owner wins.
    always_comb begin
        w_pick = r_last_owner;
        w_best = int'(NumReq);
        w_dist = 0;
        for (int j = 0; j < int'(NumReq); j++) begin
            w_dist = (j + int'(NumReq) - int'(r_last_owner) - 1) % int'(NumReq);
            if (req_i[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = OW'(j);
            end
        end
        w_pick_oh = NumReq'(1) << w_pick;
    end

    assign w_act = (r_state == S_ACTIVE);
    assign w_np  = w_act && !r_pend_proc;

    assign gnt_o              = r_gnt;
    assign done_o             = r_done;
    assign owner_o            = r_owner;
    assign timeout_o          = r_timeout;
    assign violation_o        = r_violation;
    assign eng_sha_en_o       = (r_state != S_ABORT);
    assign eng_hash_start_o   = w_np && w_start;
    assign eng_msg_req_o      = w_np && w_wvalid;
    assign eng_msg_we_o       = w_np && w_wvalid;
    assign eng_msg_wdata_o    = w_np ? w_wdata : 32'd0;
    assign eng_msg_mask_o     = w_np ? w_mask : 4'd0;
    assign eng_hash_process_o = (w_np && w_process && !w_wvalid) || (w_act && r_pend_proc);
    assign wready_o           = r_gnt & {NumReq{w_np && eng_msg_gnt_i}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(NumReq - 1);
            r_pend_proc  <= 1'b0;
            r_wd         <= '0;
            r_abort_cnt  <= 1'b0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_timeout    <= 1'b0;
            r_violation  <= 1'b0;
        end else begin
            r_done      <= '0;
            r_timeout   <= 1'b0;
            r_violation <= |((start_i | process_i | wvalid_i) & ~r_gnt);
            case (r_state)
                S_IDLE: begin
                    r_pend_proc <= 1'b0;
                    if (|req_i) begin
                        r_owner <= w_pick;
                        r_gnt   <= w_pick_oh;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (r_pend_proc) begin
                        r_pend_proc <= 1'b0;
                        r_wd        <= '0;
                        r_state     <= S_WAIT_DONE;
                    end else if (w_process) begin
                        if (w_wvalid) begin
                            r_pend_proc <= 1'b1;
                        end else begin
                            r_wd    <= '0;
                            r_state <= S_WAIT_DONE;
                        end
                    end else if (!w_req) begin
                        r_gnt       <= '0;
                        r_abort_cnt <= 1'b0;
                        r_state     <= S_ABORT;
                    end
                end
                S_WAIT_DONE: begin
                    if (eng_hash_done_i) begin
                        r_done       <= r_gnt;
                        r_last_owner <= r_owner;
                        r_gnt        <= '0;
                        r_state      <= S_IDLE;
                    end else if (r_wd == WdW'(TimeoutCycles - 1)) begin
                        r_timeout   <= 1'b1;
                        r_gnt       <= '0;
                        r_abort_cnt <= 1'b0;
                        r_state     <= S_ABORT;
                    end else begin
                        r_wd <= r_wd + WdW'(1);
                    end
                end
                S_ABORT: begin
                    // Two cycles with the engine disabled wipe its state.
                    if (r_abort_cnt) begin
                        r_last_owner <= r_owner;
                        r_state      <= S_IDLE;
                    end else begin
                        r_abort_cnt <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
